// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU defines for the hazard controller: widths, FSM encoding, hazard helper.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 4;
  localparam int CNT_W     = 16;
  localparam int WAIT_W    = 8;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_e;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(input logic     mem_read,
                                        input reg_idx_t rd,
                                        input logic     uses_rs1,
                                        input reg_idx_t rs1,
                                        input logic     uses_rs2,
                                        input reg_idx_t rs2);
    return mem_read && (rd != '0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage status in, stall/flush controls out.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_idx_t          id_rs1;
  reg_idx_t          id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  reg_idx_t          ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              stall_pc;
  logic              stall_if_id;
  logic              stall_ex;
  logic              stall_mem;
  logic              flush_if_id;
  logic              flush_ex;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  stall_pc, stall_if_id, stall_ex, stall_mem, flush_if_id, flush_ex,
           mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output stall_pc, stall_if_id, stall_ex, stall_mem, flush_if_id, flush_ex,
           mem_timeout, stall_count, flush_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles, holding once the maximum is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use bubbles.
//
// state    | meaning
// RUN      | no memory wait in progress
// MEM_WAIT | data memory holding the pipe, wait counter running
// TIMEOUT  | wait exceeded TIMEOUT_CYCLES, still holding until memory answers
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter logic [WAIT_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  hz_state_e         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              mem_hold;
  logic              load_use;
  logic              stall_pc, stall_if_id, stall_ex, stall_mem;
  logic              flush_if_id, flush_ex;

  assign mem_hold = bus.mem_req && !bus.mem_ready;
  assign load_use = load_use_hit(bus.ex_mem_read, bus.ex_rd,
                                 bus.id_uses_rs1, bus.id_rs1,
                                 bus.id_uses_rs2, bus.id_rs2);

  // Zero-latency controls; memory hold wins, then branch flush, then load-use.
  // A taken branch seen during a hold stays in EX and flushes once the hold drops.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_if_id = 1'b0;
    flush_ex    = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        stall_ex    = 1'b1;
        stall_mem   = 1'b1;
      end else if (bus.ex_branch_taken) begin
        flush_if_id = 1'b1;
        flush_ex    = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_ex    = 1'b1;
      end
    end
  end

  // Memory-wait FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_hold) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (!mem_hold) begin
            state <= RUN;
          end else if (wait_cnt == (TIMEOUT_CYCLES - WAIT_W'(1))) begin
            state     <= TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        TIMEOUT: begin
          if (!mem_hold) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_pc),
    .count (bus.stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_ex),
    .count (bus.flush_count)
  );

  assign bus.stall_pc    = stall_pc;
  assign bus.stall_if_id = stall_if_id;
  assign bus.stall_ex    = stall_ex;
  assign bus.stall_mem   = stall_mem;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_ex    = flush_ex;
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] TC = 8'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       r;
    logic       mr;
    logic       mrdy;
    logic       br;
    logic       emr;
    logic       u1;
    logic       u2;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
  } stim_t;

  typedef struct packed {
    logic [5:0]  ctl;
    logic        to;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: counts and the length of the current memory-hold run.
  int   m_sc  = 0;
  int   m_fc  = 0;
  int   m_run = 0;
  bit   m_to  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected controls: {stall_pc, stall_if_id, stall_ex, stall_mem, flush_if_id, flush_ex}
  function automatic logic [5:0] ref_ctl(input stim_t s);
    bit hold, dep;
    hold = s.mr && !s.mrdy;
    dep  = s.emr && (s.rd != 0) &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.r)        return 6'b000000;
    if (hold)       return 6'b111100;
    if (s.br)       return 6'b000011;
    if (dep)        return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic drive(input stim_t s);
    logic [5:0] c;
    exp_t       e;
    @(posedge clk);
    #1;
    rst                 = s.r;
    bus.mem_req         = s.mr;
    bus.mem_ready       = s.mrdy;
    bus.ex_branch_taken = s.br;
    bus.ex_mem_read     = s.emr;
    bus.id_uses_rs1     = s.u1;
    bus.id_uses_rs2     = s.u2;
    bus.id_rs1          = s.rs1;
    bus.id_rs2          = s.rs2;
    bus.ex_rd           = s.rd;
    c = ref_ctl(s);
    e.ctl = c;
    e.to  = m_to;
    e.sc  = 16'(m_sc);
    e.fc  = 16'(m_fc);
    sb_q.push_back(e);
    if (s.r) begin
      m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
    end else begin
      if (c[5] && m_sc < 65535) m_sc++;
      if (c[0] && m_fc < 65535) m_fc++;
      if (s.mr && !s.mrdy) begin
        if (m_run < 1000) m_run++;
        if (m_run >= int'(TC) + 1) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ctl", 32'({bus.stall_pc, bus.stall_if_id, bus.stall_ex,
                          bus.stall_mem, bus.flush_if_id, bus.flush_ex}), 32'(e.ctl));
        check("mem_timeout", 32'(bus.mem_timeout), 32'(e.to));
        check("stall_count", 32'(bus.stall_count), 32'(e.sc));
        check("flush_count", 32'(bus.flush_count), 32'(e.fc));
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.ex_mem_read = 1'b0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;

    // Reset held with noisy inputs: outputs must stay quiet.
    s = idle(); s.r = 1; s.mr = 1; s.br = 1; s.emr = 1; s.u1 = 1; s.rs1 = 3; s.rd = 3;
    drive(s);
    drive(idle());

    // Load-use on rs1, then same with rd=0, then branch overriding load-use.
    s = idle(); s.emr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
    drive(s);
    s.rd = 0; s.rs1 = 0;
    drive(s);
    s = idle(); s.emr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1; s.br = 1;
    drive(s);
    s.br = 0; s.u2 = 0;
    drive(s);
    drive(idle());

    // Five-cycle memory hold, then completion.
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.mr = 1; drive(s);
    end
    s = idle(); s.mr = 1; s.mrdy = 1; drive(s);
    drive(idle());

    // Taken branch held in EX across a memory wait, flushing afterwards.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mr = 1; s.br = 1; drive(s);
    end
    s = idle(); s.br = 1; drive(s);
    drive(idle());

    // Ten-cycle hold with TIMEOUT_CYCLES=4: sticky timeout until reset.
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.mr = 1; drive(s);
    end
    s = idle(); s.mr = 1; s.mrdy = 1; drive(s);
    for (int i = 0; i < 3; i++) drive(idle());
    s = idle(); s.r = 1; drive(s);
    drive(idle());

    // Reset in the middle of a memory wait.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.mr = 1; drive(s);
    end
    s = idle(); s.r = 1; s.mr = 1; drive(s);
    drive(idle());
    s = idle(); s.emr = 1; s.rd = 2; s.rs1 = 2; s.u1 = 1; drive(s);

    // Randomised traffic with narrow register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      s.r    = ($urandom_range(0, 99) == 0);
      s.mr   = ($urandom_range(0, 3) == 0);
      s.mrdy = ($urandom_range(0, 2) == 0);
      s.br   = ($urandom_range(0, 5) == 0);
      s.emr  = 1'($urandom_range(0, 1));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.rs1  = 4'($urandom_range(0, 3));
      s.rs2  = 4'($urandom_range(0, 3));
      s.rd   = 4'($urandom_range(0, 3));
      drive(s);
    end

    // Long hold to drive stall_count into saturation.
    s = idle(); s.r = 1; drive(s);
    for (int i = 0; i < 65540; i++) begin
      s = idle(); s.mr = 1; drive(s);
    end
    s = idle(); s.emr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; drive(s);
    drive(idle());

    @(negedge clk);
    #1;
    check("stall_count_saturated", 32'(bus.stall_count), 32'hFFFF);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
